// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
package regfile_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_wr_arb.sv
// Per-address write arbitration: which port wins each address, and whether
// two enabled ports collided on the same nonzero address.
module regfile_wr_arb
    import regfile_pkg::*;
#(
    parameter int  NREG = NREG_DEF,
    parameter int  NWR  = 2,
    localparam int AW   = $clog2(NREG),
    localparam int PW   = (NWR > 1) ? $clog2(NWR) : 1
) (
    input  logic [NWR-1:0]     wr_en,
    input  logic [NWR*AW-1:0]  wr_addr,
    output logic [NREG-1:0]    hit,
    output logic [NREG*PW-1:0] sel,
    output logic               conflict
);

    logic match_s;

    // Later ports overwrite earlier ones, so the highest-index match wins.
    always_comb begin
        hit      = {NREG{1'b0}};
        sel      = {(NREG*PW){1'b0}};
        conflict = 1'b0;
        match_s  = 1'b0;
        for (int a = 1; a < NREG; a++) begin
            for (int p = 0; p < NWR; p++) begin
                match_s         = wr_en[p] && (wr_addr[p*AW +: AW] == AW'(a));
                hit[a]          = hit[a] | match_s;
                sel[a*PW +: PW] = match_s ? PW'(p) : sel[a*PW +: PW];
            end
        end
        for (int i = 0; i < NWR; i++) begin
            for (int j = i + 1; j < NWR; j++) begin
                conflict = conflict |
                           (wr_en[i] & wr_en[j] &
                            (wr_addr[i*AW +: AW] == wr_addr[j*AW +: AW]) &
                            (wr_addr[i*AW +: AW] != {AW{1'b0}}));
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with hardwired x0, optional write-to-read bypass
// and a sequential clear engine that also runs after every reset.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int  XLEN   = XLEN_DEF,
    parameter int  NREG   = NREG_DEF,
    parameter int  NRD    = 2,
    parameter int  NWR    = 2,
    parameter int  BYPASS = 1,
    localparam int AW     = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                clr_req,
    output logic                busy,
    output logic                wr_conflict
);

    localparam int             PW       = (NWR > 1) ? $clog2(NWR) : 1;
    localparam logic [AW-1:0]  CNT_ONE  = AW'(1'b1);
    localparam logic [AW-1:0]  CNT_LAST = AW'(NREG - 1);

    state_t               state_r;
    logic [AW-1:0]        cnt_r;
    logic                 wr_conflict_r;
    logic [XLEN-1:0]      mem_r [NREG];
    logic                 busy_s;
    logic [NWR-1:0]       wr_en_s;
    logic [NREG-1:0]      hit_s;
    logic [NREG*PW-1:0]   sel_s;
    logic                 conflict_s;
    logic [AW-1:0]        rd_a_s;

    assign busy_s      = (state_r == CLEAR);
    assign busy        = busy_s;
    assign wr_conflict = wr_conflict_r;
    // Gating the enables here silences both storage writes and bypass while clearing.
    assign wr_en_s     = busy_s ? {NWR{1'b0}} : wr_en;

    regfile_wr_arb #(
        .NREG (NREG),
        .NWR  (NWR)
    ) u_wr_arb (
        .wr_en    (wr_en_s),
        .wr_addr  (wr_addr),
        .hit      (hit_s),
        .sel      (sel_s),
        .conflict (conflict_s)
    );

    // Clear sequencer and registered collision flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= CLEAR;
            cnt_r         <= CNT_ONE;
            wr_conflict_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (clr_req) begin
                        state_r       <= CLEAR;
                        cnt_r         <= CNT_ONE;
                        wr_conflict_r <= 1'b0;
                    end else begin
                        wr_conflict_r <= conflict_s;
                    end
                end
                CLEAR: begin
                    wr_conflict_r <= 1'b0;
                    if (cnt_r == CNT_LAST) begin
                        state_r <= IDLE;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r       <= CLEAR;
                    cnt_r         <= CNT_ONE;
                    wr_conflict_r <= 1'b0;
                end
            endcase
        end
    end

    // Storage array; deliberately not reset, the clear sequence zeroes it.
    always_ff @(posedge clk) begin
        if (busy_s) begin
            mem_r[cnt_r] <= {XLEN{1'b0}};
        end else begin
            for (int a = 1; a < NREG; a++) begin
                if (hit_s[a]) begin
                    mem_r[a] <= wr_data[int'(sel_s[a*PW +: PW])*XLEN +: XLEN];
                end
            end
        end
    end

    // Combinational read ports with x0, busy/reset masking and optional bypass.
    always_comb begin
        rd_data = {(NRD*XLEN){1'b0}};
        rd_a_s  = {AW{1'b0}};
        for (int r = 0; r < NRD; r++) begin
            rd_a_s = rd_addr[r*AW +: AW];
            if (!reset_n || busy_s || (rd_a_s == {AW{1'b0}})) begin
                rd_data[r*XLEN +: XLEN] = {XLEN{1'b0}};
            end else if ((BYPASS != 32'sd0) && hit_s[rd_a_s]) begin
                rd_data[r*XLEN +: XLEN] =
                    wr_data[int'(sel_s[int'(rd_a_s)*PW +: PW])*XLEN +: XLEN];
            end else begin
                rd_data[r*XLEN +: XLEN] = mem_r[rd_a_s];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: one bypassing and one non-bypassing instance share all inputs.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data_b, rd_data_n;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        clr_req;
    logic        busy_b, busy_n, conf_b, conf_n;
    int          checks = 0;
    int          errors = 0;
    int          n;

    always #5 clk = ~clk;

    regfile_mp #(.BYPASS(1)) dut (
        .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_req(clr_req), .busy(busy_b), .wr_conflict(conf_b)
    );

    regfile_mp #(.BYPASS(0)) dut_nb (
        .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_req(clr_req), .busy(busy_n), .wr_conflict(conf_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic wr0(input logic [4:0] a, input logic [31:0] d);
        wr_en   = 2'b01;
        wr_addr = {5'd0, a};
        wr_data = {32'h0, d};
    endtask

    task automatic idle_in();
        wr_en   = 2'b00;
        clr_req = 1'b0;
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy_b === 1'b1 && cnt < 100) begin
            cnt++;
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; clr_req = 1'b0; wr_en = 2'b00;
        wr_addr = 10'd0; wr_data = 64'd0; rd_addr = {5'd9, 5'd5};
        #12;
        chk("rst_busy", {31'd0, busy_b}, 32'd1);
        chk("rst_conflict", {31'd0, conf_b}, 32'd0);
        chk("rst_rd_p0", rd_data_b[31:0], 32'd0);
        chk("rst_rd_p1", rd_data_b[63:32], 32'd0);
        step(); step();
        reset_n = 1'b1;
        #1;
        count_busy(n);
        chk("rst_busy_cycles", n, 32'd31);
        chk("nb_busy_low", {31'd0, busy_n}, 32'd0);
        for (int a = 0; a < 32; a++) begin
            set_rd(5'(a), 5'(31 - a));
            #1;
            chk("init_zero_p0", rd_data_b[31:0], 32'd0);
            chk("init_zero_p1", rd_data_n[63:32], 32'd0);
        end

        // Basic write then read on both ports; x0 discards writes.
        wr0(5'd5, 32'hDEADBEEF);
        step(); idle_in();
        set_rd(5'd5, 5'd5);
        #1;
        chk("x5_p0", rd_data_b[31:0], 32'hDEADBEEF);
        chk("x5_p1", rd_data_b[63:32], 32'hDEADBEEF);
        chk("x5_nb_p0", rd_data_n[31:0], 32'hDEADBEEF);
        chk("x5_noconf", {31'd0, conf_b}, 32'd0);
        wr0(5'd0, 32'h1234);
        set_rd(5'd0, 5'd0);
        #1;
        chk("x0_bypass", rd_data_b[31:0], 32'd0);
        step(); idle_in();
        #1;
        chk("x0_read", rd_data_b[31:0], 32'd0);
        chk("x0_read_nb", rd_data_n[63:32], 32'd0);

        // Same-address collision: port1 wins, flag for one cycle.
        wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h22, 32'h11};
        set_rd(5'd7, 5'd7);
        #1;
        chk("coll_pre_flag", {31'd0, conf_b}, 32'd0);
        chk("coll_bypass_hi", rd_data_b[31:0], 32'h22);
        step(); idle_in();
        #1;
        chk("coll_flag", {31'd0, conf_b}, 32'd1);
        chk("coll_flag_nb", {31'd0, conf_n}, 32'd1);
        chk("coll_x7", rd_data_n[31:0], 32'h22);
        step();
        chk("coll_flag_drop", {31'd0, conf_b}, 32'd0);
        wr_en = 2'b11; wr_addr = {5'd0, 5'd0}; wr_data = {32'h5, 32'h6};
        step(); idle_in();
        chk("x0_coll_noflag", {31'd0, conf_b}, 32'd0);
        wr_en = 2'b11; wr_addr = {5'd9, 5'd8}; wr_data = {32'h99, 32'h88};
        step(); idle_in();
        set_rd(5'd8, 5'd9);
        #1;
        chk("dual_noflag", {31'd0, conf_b}, 32'd0);
        chk("dual_x8", rd_data_b[31:0], 32'h88);
        chk("dual_x9", rd_data_b[63:32], 32'h99);

        // Bypass versus stored value.
        wr0(5'd3, 32'h33);
        step(); idle_in();
        wr0(5'd3, 32'hA5A5A5A5);
        set_rd(5'd3, 5'd3);
        #1;
        chk("byp_p0", rd_data_b[31:0], 32'hA5A5A5A5);
        chk("byp_p1", rd_data_b[63:32], 32'hA5A5A5A5);
        chk("nobyp_old", rd_data_n[31:0], 32'h33);
        step(); idle_in();
        #1;
        chk("nobyp_new", rd_data_n[31:0], 32'hA5A5A5A5);

        // Fill, then clear with a dropped write at cnt=10 and an ignored clr_req.
        for (int a = 1; a < 32; a++) begin
            wr0(5'(a), 32'h1000_0000 | 32'(a));
            step();
        end
        idle_in();
        set_rd(5'd31, 5'd1);
        #1;
        chk("fill_x31", rd_data_b[31:0], 32'h1000_001F);
        chk("fill_x1", rd_data_n[63:32], 32'h1000_0001);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        n = 0;
        while (busy_b === 1'b1 && n < 100) begin
            if (n == 9) begin
                wr_en = 2'b11; wr_addr = {5'd5, 5'd5}; wr_data = {32'hBAD2, 32'hBAD1};
                set_rd(5'd31, 5'd5);
                #1;
                chk("busy_rd_p0", rd_data_b[31:0], 32'd0);
                chk("busy_rd_p1", rd_data_b[63:32], 32'd0);
            end else begin
                wr_en = 2'b00;
            end
            if (n == 10) begin
                chk("busy_noflag", {31'd0, conf_b}, 32'd0);
            end
            clr_req = (n == 20);
            n++;
            step();
        end
        idle_in();
        chk("clr_busy_cycles", n, 32'd31);
        wr0(5'd4, 32'h44);
        set_rd(5'd31, 5'd4);
        #1;
        chk("post_clr_x31", rd_data_b[31:0], 32'd0);
        chk("post_clr_nb_x4", rd_data_n[63:32], 32'd0);
        step(); idle_in();
        set_rd(5'd4, 5'd5);
        #1;
        chk("post_clr_wr_x4", rd_data_b[31:0], 32'h44);
        chk("dropped_x5", rd_data_b[63:32], 32'd0);
        for (int a = 1; a < 32; a++) begin
            if (a != 4) begin
                set_rd(5'(a), 5'(a));
                #1;
                chk("post_clr_zero", rd_data_n[31:0], 32'd0);
            end
        end

        // Reset in the middle of a clear restarts the full sequence.
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int k = 0; k < 14; k++) step();
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy_b}, 32'd1);
        chk("midrst_rd", rd_data_b[31:0], 32'd0);
        step(); step();
        reset_n = 1'b1;
        #1;
        count_busy(n);
        chk("midrst_busy_cycles", n, 32'd31);
        set_rd(5'd4, 5'd2);
        #1;
        chk("midrst_x4", rd_data_b[31:0], 32'd0);
        chk("midrst_x2", rd_data_b[63:32], 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
